// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NREQ write requesters, the arbiter and the
// downstream FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = 16
);
    localparam int IDW = $clog2(NREQ);

    // Requester side: one valid/last/ready bit and one payload slice each
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_last;
    logic [NREQ*DATAWIDTH-1:0] req_data;
    logic [NREQ-1:0]           req_ready;

    // FIFO write side
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [IDW+DATAWIDTH-1:0]  fifo_din;

    // Status
    logic                      grant_valid;
    logic [IDW-1:0]            grant_id;
    logic [15:0]               stall_cnt;

    // Requesters and FIFO model drive the inputs of the arbiter
    modport master (
        output req_valid,
        output req_last,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_din,
        input  grant_valid,
        input  grant_id,
        input  stall_cnt
    );

    // The arbiter itself
    modport slave (
        input  req_valid,
        input  req_last,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_wr_en,
        output fifo_din,
        output grant_valid,
        output grant_id,
        output stall_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one synchronous FIFO write port among
// NREQ requesters. A grant lasts until the requester's last beat or until
// MAXBURST beats have been written; the FIFO word carries the requester id
// above the payload so the reader can demultiplex.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = 16,
    parameter int MAXBURST  = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    fifo_wr_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAXBURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Registered state
    state_t           state_q,     state_d;
    logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [IDW-1:0]   grant_id_q,  grant_id_d;
    logic [CW-1:0]    beat_cnt_q,  beat_cnt_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    // Unpacked view of the requester payloads
    logic [DATAWIDTH-1:0] req_data_arr [NREQ];

    // Round-robin scan candidates: slot gi holds requester (rr_ptr+gi) mod NREQ
    logic [IDW:0]     cand_sum [NREQ];
    logic [IDW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0]  cand_hit;

    // Arbitration result
    logic             any_req;
    logic [IDW-1:0]   winner;

    // Signals of the currently granted requester
    logic                 sel_valid;
    logic                 sel_last;
    logic [DATAWIDTH-1:0] sel_data;

    // Combinational outputs
    logic [NREQ-1:0]          req_ready_c;
    logic                     fifo_wr_en_c;
    logic [IDW+DATAWIDTH-1:0] fifo_din_c;
    logic                     grant_valid_c;

    // Burst termination
    logic [CW:0]      beat_cnt_inc;
    logic             burst_end;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_data_arr[gi] = bus.req_data[gi*DATAWIDTH +: DATAWIDTH];

            // Modular add without a divider so non-power-of-two NREQ wraps to 0
            assign cand_sum[gi] = {1'b0, rr_ptr_q} + (IDW+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (IDW+1)'(NREQ))
                                ? IDW'(cand_sum[gi] - (IDW+1)'(NREQ))
                                : IDW'(cand_sum[gi]);
            assign cand_hit[gi] = bus.req_valid[cand_idx[gi]];
        end
    endgenerate

    assign any_req = |cand_hit;

    // Pick the first valid requester in scan order starting at rr_ptr
    always_comb begin
        logic found;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && cand_hit[i]) begin
                winner = cand_idx[i];
                found  = 1'b1;
            end
        end
    end

    assign sel_valid = bus.req_valid[grant_id_q];
    assign sel_last  = bus.req_last[grant_id_q];
    assign sel_data  = req_data_arr[grant_id_q];

    // State register: all flops of the block, cleared asynchronously
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Output decode: only the granted requester sees ready, and only while
    // the FIFO has room; nothing moves during the arbitration cycle
    always_comb begin
        req_ready_c   = '0;
        fifo_wr_en_c  = 1'b0;
        fifo_din_c    = '0;
        grant_valid_c = 1'b0;
        if (state_q == BURST) begin
            grant_valid_c           = 1'b1;
            req_ready_c[grant_id_q] = !bus.fifo_full;
            fifo_wr_en_c            = sel_valid & !bus.fifo_full;
            fifo_din_c              = {grant_id_q, sel_data};
        end
    end

    assign beat_cnt_inc = {1'b0, beat_cnt_q} + (CW+1)'(1);
    assign burst_end    = fifo_wr_en_c
                        & (sel_last | (beat_cnt_inc == (CW+1)'(MAXBURST)));

    // Next-state logic: grant in IDLE, count beats and close the burst in BURST
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_id_d = winner;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                // A bubble (granted requester not valid) simply holds everything
                if (fifo_wr_en_c) begin
                    beat_cnt_d = beat_cnt_inc[CW-1:0];
                end
                if (burst_end) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_id_q == IDW'(NREQ - 1))
                             ? '0 : grant_id_q + IDW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Stalls count only cycles where a real beat is held back by the FIFO
        if ((state_q == BURST) && sel_valid && bus.fifo_full
            && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.fifo_wr_en  = fifo_wr_en_c;
    assign bus.fifo_din    = fifo_din_c;
    assign bus.grant_valid = grant_valid_c;
    assign bus.grant_id    = grant_id_q;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule
